// File: rtl/rect_fill_engine_if.sv
// Command/pixel bus between a drawing client and rect_fill_engine.
// Handshake: start is a request; it is accepted only when busy is low (engine IDLE) and
// ignored otherwise. plot is a valid-only strobe with no ready/backpressure: each high
// cycle carries one pixel (x, y, colour). finished_draw pulses once per accepted command.
interface rect_fill_engine_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       finished_draw;

  modport master (
    output start, x0, y0, w, h, colour_in,
    input  x, y, colour, plot, busy, finished_draw
  );

  modport slave (
    input  start, x0, y0, w, h, colour_in,
    output x, y, colour, plot, busy, finished_draw
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: rasterises a clipped solid rectangle into a pixel stream,
// one pixel per cycle, for a vga_adapter-style framebuffer writer.
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  rect_fill_engine_if.slave     bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);

  state_t     state;
  logic [7:0] x0_r;
  logic [6:0] y0_r;
  logic [7:0] w_r;
  logic [6:0] h_r;
  logic [2:0] colour_r;
  logic [8:0] xe_r;
  logic [7:0] ye_r;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       busy_q;
  logic       fin_q;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic [8:0] xe_clip;
  logic [7:0] ye_clip;
  logic       empty_rect;
  logic       last_col;
  logic       last_row;

  // Sums are one bit wider than the operands so a far-right/bottom rectangle cannot wrap.
  always_comb begin
    x_sum      = {1'b0, x0_r} + {1'b0, w_r};
    y_sum      = {1'b0, y0_r} + {1'b0, h_r};
    xe_clip    = (x_sum > SW) ? SW : x_sum;
    ye_clip    = (y_sum > SH) ? SH : y_sum;
    empty_rect = (w_r == 8'd0) || (h_r == 7'd0) ||
                 ({1'b0, x0_r} >= SW) || ({1'b0, y0_r} >= SH);
    last_col   = (({1'b0, x_q} + 9'd1) == xe_r);
    last_row   = (({1'b0, y_q} + 8'd1) == ye_r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
      xe_r     <= '0;
      ye_r     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x0_r     <= bus.x0;
            y0_r     <= bus.y0;
            w_r      <= bus.w;
            h_r      <= bus.h;
            colour_r <= bus.colour_in;
            busy_q   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          xe_r <= xe_clip;
          ye_r <= ye_clip;
          if (empty_rect) begin
            fin_q <= 1'b1;
            state <= DONE;
          end else begin
            x_q      <= x0_r;
            y_q      <= y0_r;
            colour_q <= colour_r;
            plot_q   <= 1'b1;
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (last_col) begin
            if (last_row) begin
              plot_q <= 1'b0;
              fin_q  <= 1'b1;
              state  <= DONE;
            end else begin
              x_q <= x0_r;
              y_q <= y_q + 7'd1;
            end
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        DONE: begin
          fin_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.colour        = colour_q;
  assign bus.plot          = plot_q;
  assign bus.busy          = busy_q;
  assign bus.finished_draw = fin_q;
  assign state_dbg         = state;

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SCREEN_W, 160, framebuffer width in pixels.
REQ-002 SCREEN_H, 120, framebuffer height in pixels.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to draw one rectangle; sampled only in IDLE.
REQ-006 x0  input  8  left column of rectangle.
REQ-007 y0  input  7  top row of rectangle.
REQ-008 w  input  8  width in pixels.
REQ-009 h  input  7  height in pixels.
REQ-010 colour_in  input  3  fill colour (RGB, 1 bit each).
REQ-011 x  output  8  pixel column to vga_adapter.
REQ-012 y  output  7  pixel row to vga_adapter.
REQ-013 colour  output  3  pixel colour to vga_adapter.
REQ-014 plot  output  1  write strobe to vga_adapter; one pixel per high cycle.
REQ-015 busy  output  1  high from start acceptance until done cycle inclusive.
REQ-016 finished_draw  output  1  single-cycle pulse when rectangle complete.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DRAW, DONE.
REQ-018 IDLE: start=1 SHALL latch x0, y0, w, h, colour_in and go to LOAD; start=0 SHALL stay IDLE.
REQ-019 start in any state other than IDLE SHALL be ignored; latched parameters SHALL not change until next IDLE acceptance.
REQ-020 LOAD SHALL compute clipped end bounds: xe = min(x0+w, SCREEN_W), ye = min(y0+h, SCREEN_H), sums 9-bit / 8-bit wide with no wrap.
REQ-021 LOAD SHALL go to DONE when w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H; otherwise to DRAW with counters at (x0, y0).
REQ-022 DRAW SHALL assert plot every cycle with x, y = current counters and colour = latched colour.
REQ-023 Traversal SHALL be raster order: x increments each cycle; at x=xe-1, x returns to x0 and y increments.
REQ-024 At x=xe-1 and y=ye-1 the FSM SHALL go to DONE after that pixel's cycle.
REQ-025 No pixel with x>=SCREEN_W or y>=SCREEN_H SHALL ever be plotted.
REQ-026 Plotted pixel count SHALL equal (xe-x0)*(ye-y0); each pixel exactly once.
REQ-027 DONE SHALL assert finished_draw for exactly one cycle, then go to IDLE.
REQ-028 Latency: start accepted in cycle N -> LOAD in N+1 -> first plot in N+2; finished_draw one cycle after the last plot.
REQ-029 Back-to-back: start high in the IDLE cycle after DONE SHALL be accepted; minimum command spacing = pixel count + 3 cycles.
REQ-030 plot SHALL be 0 in IDLE, LOAD and DONE; x, y, colour hold last values when plot=0.

Reset
REQ-031 reset=1 SHALL force, on the next edge, state IDLE, plot=0, busy=0, finished_draw=0, x=0, y=0, colour=0, latched parameters cleared.
REQ-032 reset asserted mid-DRAW SHALL abort with no further plot and no finished_draw pulse.
REQ-033 reset and start high on the same edge: reset SHALL win; start ignored.

Verification
REQ-034 x0=10,y0=20,w=3,h=2,colour_in=3'b100, pulse start -> plot 6 cycles: (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), colour 100, first at start+2, finished_draw at start+8.
REQ-035 x0=158,y0=118,w=5,h=5 -> only (158,118)(159,118)(158,119)(159,119) plotted; finished_draw after 4th pixel.
REQ-036 w=0 (or x0=200) with start -> zero plot cycles, finished_draw at start+2, busy high start+1..start+2.
REQ-037 start re-pulsed during DRAW of 4x4 rectangle with different params -> exactly 16 pixels of original rectangle, second start ignored.
REQ-038 reset asserted after 5th pixel of 8x8 rectangle -> plot 0 from next cycle, no finished_draw, all outputs 0, next start accepted normally.
REQ-039 two 1x1 commands back-to-back (second start in IDLE cycle after first finished_draw) -> both pixels plotted, two finished_draw pulses 4 cycles apart.
